// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state codes, frame size
// and the bit-period arithmetic derived from clock and line rate.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    // Receiver FSM state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Clocks per bit, rounded to nearest
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    // Clocks to the middle of the start bit
    function automatic int unsigned calc_half(input int unsigned clk_freq,
                                              input int unsigned baud);
        return calc_div(clk_freq, baud) / 2;
    endfunction

    // True when the rounded divider keeps the baud error below 2 %
    function automatic bit baud_ok(input int unsigned clk_freq,
                                   input int unsigned baud);
        longint unsigned actual;
        longint unsigned err;
        actual = longint'(calc_div(clk_freq, baud)) * longint'(baud);
        err    = (actual > longint'(clk_freq)) ? actual - longint'(clk_freq)
                                               : longint'(clk_freq) - actual;
        return (err * 64'd50) < longint'(clk_freq);
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period down-counter. A load presets the count; when it reaches zero
// it raises tick for one cycle and reloads a full bit period by itself.
module rx_bit_timer #(
    parameter int unsigned DIV = 104,
    parameter int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,  // already N-1
    input  logic         en,
    output logic         tick
);

    localparam logic [W-1:0] RELOAD = W'(DIV - 1);

    logic [W-1:0] count;

    // Counter: load wins over counting, auto-reload on zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (count == '0) ? RELOAD : count - W'(1);
        end
    end

    assign tick = en && (count == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start qualification,
// centre sampling of data and stop bits, single-cycle valid/error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq = 12000000,
    parameter int unsigned baud     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV  = calc_div(clk_freq, baud);
    localparam int unsigned HALF = calc_half(clk_freq, baud);
    localparam int unsigned TW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
    localparam logic [TW-1:0] DIV_M1  = TW'(DIV - 1);

    if (!baud_ok(clk_freq, baud)) begin : g_baud_err
        $error("uart_rx: rounded bit divider gives more than 2%% baud error");
    end

    logic          rx_m, rx_s;
    logic [2:0]    state, state_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shreg, shreg_d;
    logic [7:0]    data_d;
    logic          data_valid_d, frame_err_d;
    logic          tmr_load, tmr_en, tick;
    logic [TW-1:0] tmr_load_val;

    // Two-flop synchroniser for the asynchronous line, idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign tmr_en = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);

    rx_bit_timer #(
        .DIV (DIV),
        .W   (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .tick     (tick)
    );

    // Next-state logic for the frame FSM, shift register and strobes
    always_comb begin
        state_d      = state;
        bit_idx_d    = bit_idx;
        shreg_d      = shreg;
        data_d       = data;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = HALF_M1;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = HALF_M1;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = DIV_M1;
                        bit_idx_d    = 3'd0;
                        state_d      = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;  // glitch, not a real start bit
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d[bit_idx] = rx_s;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        data_d       = shreg;
                        data_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off until the line is released so a held-low line is not a start
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            data       <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_d;
            bit_idx    <= bit_idx_d;
            shreg      <= shreg_d;
            data       <= data_d;
            data_valid <= data_valid_d;
            frame_err  <= frame_err_d;
        end
    end

    // Busy covers the strobe cycle too, dropping the cycle after it
    assign busy = (state != ST_IDLE) || data_valid || frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: byte frames, back-to-back frames, a start
// glitch, a framing error with held-low line, mid-frame reset, and a
// default-parameter frame. Expected bytes and strobe cycles go through
// queues and are matched when the receiver strobes.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_def = 1'b1;
    logic [7:0] data, data_def;
    logic       dv, fe, busy, dv_def, fe_def, busy_def;

    uart_rx #(
        .clk_freq (12000000),
        .baud     (1000000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .data_valid (dv),
        .frame_err  (fe),
        .busy       (busy)
    );

    uart_rx dut_def (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_def),
        .data       (data_def),
        .data_valid (dv_def),
        .frame_err  (fe_def),
        .busy       (busy_def)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t       sb_q[$];
    int         fe_q[$];
    int         nassert = 0;
    int         nfail = 0;
    logic [7:0] exp_data = 8'h00;
    int         t0 = 0;
    int         busy_rise = -1;
    int         busy_fall = -1;
    logic       busy_prev = 1'b0;
    int         def_cnt = 0;
    int         def_cyc = -1;
    int         def_fe_cnt = 0;
    logic [7:0] def_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit def, input logic v);
        if (def) rx_def = v;
        else rx = v;
    endtask

    // One frame: start, 8 data bits LSB first, stop bit of value stopv
    task automatic send_frame(input logic [7:0] b, input logic stopv, input bit def,
                              input bit push);
        int div;
        div = def ? 104 : 12;
        t0 = cyc;
        if (push) begin
            sb_q.push_back('{b, cyc + 117});
            exp_data = b;
        end
        set_line(def, 1'b0);
        tick_n(div);
        for (int i = 0; i < 8; i++) begin
            set_line(def, b[i]);
            tick_n(div);
        end
        set_line(def, stopv);
        tick_n(div);
    endtask

    // Scoreboard and line-event monitor, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (dv) begin
            check("dv_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("dv_data", 32'(data), 32'(e.d));
                check("dv_cycle", 32'(cyc), 32'(e.c));
            end
        end
        if (fe) begin
            check("fe_expected", 32'(fe_q.size() != 0), 32'd1);
            if (fe_q.size() != 0) begin
                check("fe_cycle", 32'(cyc), 32'(fe_q.pop_front()));
            end
            check("fe_data_held", 32'(data), 32'(exp_data));
            check("fe_dv_exclusive", 32'(dv), 32'd0);
        end
        if (busy && !busy_prev) busy_rise = cyc;
        if (!busy && busy_prev) busy_fall = cyc;
        busy_prev = busy;
        if (dv_def) begin
            def_cnt++;
            def_cyc  = cyc;
            def_data = data_def;
        end
        if (fe_def) def_fe_cnt++;
    end

    initial begin
        int         s6;
        logic [7:0] b;

        // Reset state
        tick_n(3);
        check("rst_data", 32'(data), 32'h00);
        check("rst_dv", 32'(dv), 32'd0);
        check("rst_fe", 32'(fe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick_n(5);

        // 1: single 0xA5 frame
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        tick_n(5);
        check("s1_busy_rise", 32'(busy_rise), 32'(t0 + 3));
        check("s1_busy_fall", 32'(busy_fall), 32'(t0 + 118));
        check("s1_pending", 32'(sb_q.size()), 32'd0);

        // 2: back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        tick_n(5);
        check("s2_pending", 32'(sb_q.size()), 32'd0);
        check("s2_data", 32'(data), 32'hFF);

        // 3: three-cycle low glitch
        t0 = cyc;
        rx = 1'b0;
        tick_n(3);
        rx = 1'b1;
        tick_n(40);
        check("s3_busy_rise", 32'(busy_rise), 32'(t0 + 3));
        check("s3_busy_fall", 32'(busy_fall), 32'(t0 + 9));
        check("s3_data", 32'(data), 32'hFF);

        // 4: 0x3C with low stop bit, line held low 50 more cycles
        fe_q.push_back(cyc + 117);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tick_n(50);
        rx = 1'b1;
        tick_n(10);
        check("s4_fe_pending", 32'(fe_q.size()), 32'd0);
        check("s4_busy_rise", 32'(busy_rise), 32'(t0 + 3));
        check("s4_busy_fall", 32'(busy_fall), 32'(t0 + 173));
        check("s4_data", 32'(data), 32'hFF);

        // 5: reset at t=60 inside a 0x81 frame, then a clean 0x81
        b  = 8'h81;
        t0 = cyc;
        rx = 1'b0;
        tick_n(12);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick_n(12);
        end
        rst = 1'b1;
        rx  = 1'b1;
        tick_n(1);
        check("s5_rst_data", 32'(data), 32'h00);
        check("s5_rst_dv", 32'(dv), 32'd0);
        check("s5_rst_fe", 32'(fe), 32'd0);
        check("s5_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        exp_data = 8'h00;
        tick_n(30);
        check("s5_idle_busy", 32'(busy), 32'd0);
        check("s5_idle_data", 32'(data), 32'h00);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        tick_n(5);
        check("s5_pending", 32'(sb_q.size()), 32'd0);
        check("s5_data", 32'(data), 32'h81);

        // 6: 0xA5 at default parameters
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        s6 = t0;
        tick_n(20);
        check("s6_count", 32'(def_cnt), 32'd1);
        check("s6_cycle", 32'(def_cyc), 32'(s6 + 991));
        check("s6_data", 32'(def_data), 32'hA5);
        check("s6_fe", 32'(def_fe_cnt), 32'd0);

        check("end_sb_empty", 32'(sb_q.size()), 32'd0);
        check("end_fe_empty", 32'(fe_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
